// File: rtl/arb_pkg.sv
// Shared encodings for the IF/MEM Wishbone arbiter: FSM states and one-hot grant values.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_OH_I = 2'b01;
    localparam logic [1:0] GNT_OH_D = 2'b10;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags the last one before the cycle is aborted.
module wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Count reaches LAST on the TIMEOUT-th stalled cycle; the top clears on expiry.
    assign expired_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch / data) to one-slave Wishbone arbiter with data priority,
// fetch starvation guard and a hung-slave watchdog.
module wb_mem_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] i_addr_i,
    input  logic        i_cyc_i,
    input  logic        i_stb_i,
    output logic [31:0] i_dat_o,
    output logic        i_ack_o,
    output logic        i_err_o,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_dat_i,
    input  logic [3:0]  d_sel_i,
    input  logic        d_we_i,
    input  logic        d_cyc_i,
    input  logic        d_stb_i,
    output logic [31:0] d_dat_o,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  grant_o
);

    localparam int             SCW        = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    arb_state_e     state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [SCW-1:0] starve_q, starve_d;

    logic i_req, d_req, own_cyc, own_stb;
    logic wd_expired, wd_clr, timeout;

    assign i_req = i_cyc_i & i_stb_i;
    assign d_req = d_cyc_i & d_stb_i;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            GNT_I:   begin own_cyc = i_cyc_i; own_stb = i_stb_i; end
            GNT_D:   begin own_cyc = d_cyc_i; own_stb = d_stb_i; end
            default: ;
        endcase
    end

    // A same-cycle ack/err from the slave beats the watchdog.
    assign timeout = wd_expired & ~s_ack_i & ~s_err_i;
    assign wd_clr  = (state_q == IDLE) | s_ack_i | s_err_i | timeout;

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wd_clr),
        .en_i      (own_stb),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && starve_q == STARVE_LIM)) begin
                    state_d = GNT_D;
                    grant_d = GNT_OH_D;
                    if (i_req && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
                end else if (i_req) begin
                    state_d  = GNT_I;
                    grant_d  = GNT_OH_I;
                    starve_d = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (timeout || !own_cyc) begin
                    state_d = IDLE;
                    grant_d = GNT_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            grant_q  <= GNT_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
        end
    end

    assign grant_o = grant_q;
    assign i_dat_o = s_dat_i;
    assign d_dat_o = s_dat_i;

    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        case (state_q)
            GNT_I: begin
                s_addr_o = i_addr_i;
                s_sel_o  = 4'hF;
            end
            GNT_D: begin
                s_addr_o = d_addr_i;
                s_dat_o  = d_dat_i;
                s_sel_o  = d_sel_i;
                s_we_o   = d_we_i;
            end
            default: ;
        endcase
    end

    assign s_cyc_o = own_cyc & ~timeout;
    assign s_stb_o = own_stb & ~timeout;

    assign i_ack_o = (state_q == GNT_I) & s_ack_i;
    assign i_err_o = (state_q == GNT_I) & (s_err_i | timeout);
    assign d_ack_o = (state_q == GNT_D) & s_ack_i;
    assign d_err_o = (state_q == GNT_D) & (s_err_i | timeout);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: arbitration, starvation guard, watchdog, locked cycles, async reset.
module tb_wb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] i_addr_i = '0, d_addr_i = '0, d_dat_i = '0, s_dat_i = '0;
    logic [3:0]  d_sel_i = '0;
    logic        i_cyc_i = 0, i_stb_i = 0, d_we_i = 0, d_cyc_i = 0, d_stb_i = 0;
    logic        s_ack_i = 0, s_err_i = 0;
    logic [31:0] i_dat_o, d_dat_o, s_addr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        i_ack_o, i_err_o, d_ack_o, d_err_o, s_we_o, s_cyc_o, s_stb_o;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_mem_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_addr_i(i_addr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
        .d_addr_i(d_addr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i),
        .d_we_i(d_we_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
        .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
    task automatic step;
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_bus;
        i_cyc_i = 0; i_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
        d_we_i = 0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic do_reset;
        step;
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
    endtask

    task automatic test_reset;
        s_dat_i = 32'h1234_5678;
        i_cyc_i = 1; i_stb_i = 1;
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b expected 00", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errors++; $display("FAIL rst_sctl: got %b expected 000", {s_cyc_o, s_stb_o, s_we_o}); end
        checks++; if ({i_ack_o, i_err_o, d_ack_o, d_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_ackerr: got %b expected 0000", {i_ack_o, i_err_o, d_ack_o, d_err_o}); end
        checks++; if (d_dat_o !== 32'h1234_5678 || i_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rst_dat_follow: got %h/%h expected 12345678", i_dat_o, d_dat_o); end
        step; #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_hold_grant: got %b expected 00", grant_o); end
        idle_bus;
        rst_i = 1'b1;
        step;
    endtask

    task automatic test_fetch;
        d_we_i = 1; d_sel_i = 4'b0011; d_dat_i = 32'hCAFE_F00D;
        i_addr_i = 32'h100; i_cyc_i = 1; i_stb_i = 1;
        #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL fetch_pregrant: got %b expected 00", grant_o); end
        step; #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL fetch_grant: got %b expected 01", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b11 || s_addr_o !== 32'h100) begin errors++; $display("FAIL fetch_sbus: got cyc/stb %b addr %h expected 11 100", {s_cyc_o, s_stb_o}, s_addr_o); end
        checks++; if (s_we_o !== 1'b0 || s_sel_o !== 4'hF || s_dat_o !== 32'h0) begin errors++; $display("FAIL fetch_forced: got we %b sel %h dat %h expected 0 f 0", s_we_o, s_sel_o, s_dat_o); end
        step;
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (i_ack_o !== 1'b1 || i_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_ack: got ack %b dat %h expected 1 deadbeef", i_ack_o, i_dat_o); end
        checks++; if (d_ack_o !== 1'b0 || i_err_o !== 1'b0) begin errors++; $display("FAIL fetch_d_ack: got d_ack %b i_err %b expected 0 0", d_ack_o, i_err_o); end
        step;
        s_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
        #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL fetch_release_hold: got %b expected 01", grant_o); end
        step; #1;
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL fetch_idle: got grant %b cyc %b expected 00 0", grant_o, s_cyc_o); end
        d_we_i = 0;
    endtask

    task automatic test_both;
        i_cyc_i = 1; i_stb_i = 1;
        d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = 4'b0011;
        d_addr_i = 32'h200; d_dat_i = 32'hA5A5_0001;
        step; #1;
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL both_grant: got %b expected 10", grant_o); end
        checks++; if (s_we_o !== 1'b1 || s_sel_o !== 4'b0011) begin errors++; $display("FAIL both_we_sel: got %b %b expected 1 0011", s_we_o, s_sel_o); end
        checks++; if (s_addr_o !== 32'h200 || s_dat_o !== 32'hA5A5_0001) begin errors++; $display("FAIL both_addr_dat: got %h %h expected 200 a5a50001", s_addr_o, s_dat_o); end
        step;
        s_ack_i = 1;
        #1;
        checks++; if (d_ack_o !== 1'b1 || i_ack_o !== 1'b0) begin errors++; $display("FAIL both_ack_route: got d %b i %b expected 1 0", d_ack_o, i_ack_o); end
        step;
        idle_bus;
        step; #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL both_idle: got %b expected 00", grant_o); end
    endtask

    task automatic test_starve;
        logic [1:0] exp_g [6];
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        do_reset;
        for (int k = 0; k < 6; k++) begin
            i_cyc_i = 1; i_stb_i = 1;
            d_cyc_i = 1; d_stb_i = 1; d_we_i = 0;
            step; #1;
            checks++; if (grant_o !== exp_g[k]) begin errors++; $display("FAIL starve_grant[%0d]: got %b expected %b", k, grant_o, exp_g[k]); end
            s_ack_i = 1;
            step;
            s_ack_i = 0;
            if (exp_g[k] == 2'b10) begin d_cyc_i = 0; d_stb_i = 0; end
            else begin i_cyc_i = 0; i_stb_i = 0; end
            step;
        end
        idle_bus;
        step;
    endtask

    task automatic test_timeout;
        d_addr_i = 32'h300; d_cyc_i = 1; d_stb_i = 1;
        step; #1;
        checks++; if (grant_o !== 2'b10 || d_err_o !== 1'b0) begin errors++; $display("FAIL to_grant: got %b err %b expected 10 0", grant_o, d_err_o); end
        for (int k = 1; k < 15; k++) begin
            step; #1;
            checks++; if (d_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL to_early[%0d]: got err %b cyc %b expected 0 1", k, d_err_o, s_cyc_o); end
        end
        step; #1;
        checks++; if (d_err_o !== 1'b1 || i_err_o !== 1'b0) begin errors++; $display("FAIL to_err: got d %b i %b expected 1 0", d_err_o, i_err_o); end
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("FAIL to_abort: got %b expected 00", {s_cyc_o, s_stb_o}); end
        idle_bus;
        step; #1;
        checks++; if (grant_o !== 2'b00 || d_err_o !== 1'b0) begin errors++; $display("FAIL to_idle: got %b err %b expected 00 0", grant_o, d_err_o); end
    endtask

    task automatic test_ack_vs_timeout;
        i_addr_i = 32'h180; i_cyc_i = 1; i_stb_i = 1;
        step; #1;
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL avt_grant: got %b expected 01", grant_o); end
        for (int k = 1; k < 15; k++) step;
        step;
        s_ack_i = 1;
        #1;
        checks++; if (i_ack_o !== 1'b1 || i_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL avt_ack_wins: got ack %b err %b cyc %b expected 1 0 1", i_ack_o, i_err_o, s_cyc_o); end
        step;
        idle_bus;
        step; #1;
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL avt_idle: got %b expected 00", grant_o); end
    endtask

    task automatic test_rmw;
        i_addr_i = 32'h104; i_cyc_i = 1; i_stb_i = 1;
        d_addr_i = 32'h400; d_cyc_i = 1; d_stb_i = 1; d_we_i = 0;
        step; #1;
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rmw_grant: got %b expected 10", grant_o); end
        s_ack_i = 1;
        #1;
        checks++; if (d_ack_o !== 1'b1) begin errors++; $display("FAIL rmw_ack1: got %b expected 1", d_ack_o); end
        step;
        s_ack_i = 0; d_stb_i = 0;
        #1;
        checks++; if (grant_o !== 2'b10 || {s_cyc_o, s_stb_o} !== 2'b10) begin errors++; $display("FAIL rmw_locked: got %b cyc/stb %b expected 10 10", grant_o, {s_cyc_o, s_stb_o}); end
        step;
        d_stb_i = 1; d_we_i = 1;
        #1;
        checks++; if (grant_o !== 2'b10 || s_we_o !== 1'b1) begin errors++; $display("FAIL rmw_write: got %b we %b expected 10 1", grant_o, s_we_o); end
        step;
        s_ack_i = 1;
        #1;
        checks++; if (d_ack_o !== 1'b1 || i_ack_o !== 1'b0) begin errors++; $display("FAIL rmw_ack2: got d %b i %b expected 1 0", d_ack_o, i_ack_o); end
        step;
        s_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
        #1;
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rmw_drop: got %b expected 10", grant_o); end
        step; #1;
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL rmw_dead: got %b cyc %b expected 00 0", grant_o, s_cyc_o); end
        step; #1;
        checks++; if (grant_o !== 2'b01 || s_addr_o !== 32'h104) begin errors++; $display("FAIL rmw_fetch: got %b addr %h expected 01 104", grant_o, s_addr_o); end
        s_ack_i = 1;
        step;
        idle_bus;
        step;
    endtask

    task automatic test_reset_mid;
        d_addr_i = 32'h500; d_cyc_i = 1; d_stb_i = 1;
        step; #1;
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rmid_grant: got %b expected 10", grant_o); end
        step; #1;
        rst_i = 1'b0;
        #1;
        checks++; if (grant_o !== 2'b00 || {s_cyc_o, s_stb_o} !== 2'b00) begin errors++; $display("FAIL rmid_drop: got %b cyc/stb %b expected 00 00", grant_o, {s_cyc_o, s_stb_o}); end
        s_ack_i = 1;
        #1;
        checks++; if (d_ack_o !== 1'b0 || i_ack_o !== 1'b0) begin errors++; $display("FAIL rmid_late_ack: got d %b i %b expected 0 0", d_ack_o, i_ack_o); end
        s_ack_i = 0;
        rst_i = 1'b1;
        step; #1;
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rmid_regrant: got %b expected 10", grant_o); end
        s_ack_i = 1;
        step;
        idle_bus;
        step;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_both;
        test_starve;
        test_timeout;
        test_ack_vs_timeout;
        test_rmw;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
